// File: rtl/mem_arbiter.sv
// mem_arbiter: shared memory4c arbiter/sequencer for I-fill, D-fill and D write-through stores.
// Define MEM_ARB_PERF_EN to add saturating grant and busy-cycle performance counters.
module mem_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int WORDS_PER_BLK = 8,
    parameter int MEM_LAT       = 4,
    parameter int I_STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_valid,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              i_data_we,
    output logic              i_tag_we,
    output logic              d_data_we,
    output logic              d_tag_we,
    output logic              wr_done,
    output logic              busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]       perf_i_fills,
    output logic [15:0]       perf_d_fills,
    output logic [15:0]       perf_writes,
    output logic [15:0]       perf_busy_cyc
`endif
);
    localparam int WORD_W   = $clog2(WORDS_PER_BLK);
    localparam int OFF_W    = WORD_W + 1;
    localparam int BLK_W    = ADDR_W - OFF_W;
    localparam int STARVE_W = $clog2(I_STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(I_STARVE_MAX);

    typedef enum logic [1:0] {IDLE, D_FILL, I_FILL, WRITE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [BLK_W-1:0]    r_blk;
    logic [WORD_W-1:0]   r_issue_cnt;
    logic                r_issue_done;
    logic [WORD_W-1:0]   r_ret_cnt;
    logic [STARVE_W-1:0] r_i_starve;
    logic                w_fill;
    logic                w_last_ret;
    logic                w_force_i;
    logic                w_grant;

    assign w_fill     = (r_state == D_FILL) || (r_state == I_FILL);
    assign w_last_ret = w_fill && mem_valid && (r_ret_cnt == '1);
    assign w_force_i  = i_miss && (r_i_starve == STARVE_MAX);
    assign w_grant    = (r_state == IDLE) && (w_next != IDLE);

    always_comb begin
        w_next      = r_state;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        fill_addr   = '0;
        fill_data   = '0;
        i_data_we   = 1'b0;
        i_tag_we    = 1'b0;
        d_data_we   = 1'b0;
        d_tag_we    = 1'b0;
        wr_done     = 1'b0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_force_i)   w_next = I_FILL;
                else if (d_miss) w_next = D_FILL;
                else if (wr_req) w_next = WRITE;
                else if (i_miss) w_next = I_FILL;
            end
            D_FILL, I_FILL: begin
                mem_en    = !r_issue_done;
                mem_addr  = r_issue_done ? '0 : {r_blk, r_issue_cnt, 1'b0};
                fill_addr = {r_blk, r_ret_cnt, 1'b0};
                fill_data = mem_data_out;
                if (r_state == I_FILL) begin
                    i_data_we = mem_valid;
                    i_tag_we  = w_last_ret;
                end else begin
                    d_data_we = mem_valid;
                    d_tag_we  = w_last_ret;
                end
                if (w_last_ret) w_next = IDLE;
            end
            WRITE: begin
                mem_en      = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = wr_addr;
                mem_data_in = wr_data;
                wr_done     = 1'b1;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Issue and return counters run independently so reads stay pipelined behind the latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_blk        <= '0;
            r_issue_cnt  <= '0;
            r_issue_done <= 1'b0;
            r_ret_cnt    <= '0;
            r_i_starve   <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant && (w_next != WRITE)) begin
                r_blk        <= (w_next == I_FILL) ? i_addr[ADDR_W-1:OFF_W] : d_addr[ADDR_W-1:OFF_W];
                r_issue_cnt  <= '0;
                r_issue_done <= 1'b0;
                r_ret_cnt    <= '0;
            end else if (w_fill) begin
                if (!r_issue_done) begin
                    if (r_issue_cnt == '1) r_issue_done <= 1'b1;
                    else                   r_issue_cnt  <= r_issue_cnt + 1'b1;
                end
                if (mem_valid && (r_ret_cnt != '1)) r_ret_cnt <= r_ret_cnt + 1'b1;
            end
            if (!i_miss || (w_grant && (w_next == I_FILL)))
                r_i_starve <= '0;
            else if (w_grant && (r_i_starve != STARVE_MAX))
                r_i_starve <= r_i_starve + 1'b1;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [15:0] r_perf_i, r_perf_d, r_perf_w, r_perf_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_i    <= '0;
            r_perf_d    <= '0;
            r_perf_w    <= '0;
            r_perf_busy <= '0;
        end else begin
            if (w_grant && (w_next == I_FILL) && (r_perf_i != '1)) r_perf_i <= r_perf_i + 1'b1;
            if (w_grant && (w_next == D_FILL) && (r_perf_d != '1)) r_perf_d <= r_perf_d + 1'b1;
            if (w_grant && (w_next == WRITE)  && (r_perf_w != '1)) r_perf_w <= r_perf_w + 1'b1;
            if ((r_state != IDLE) && (r_perf_busy != '1))          r_perf_busy <= r_perf_busy + 1'b1;
        end
    end

    assign perf_i_fills  = r_perf_i;
    assign perf_d_fills  = r_perf_d;
    assign perf_writes   = r_perf_w;
    assign perf_busy_cyc = r_perf_busy;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a latency-4 memory model and a rule-level grant-order model.
// Build with MEM_ARB_PERF_EN defined to also check the performance counters.
module tb_mem_arbiter;
    localparam int MEM_LAT      = 4;
    localparam int WORDS        = 8;
    localparam int I_STARVE_MAX = 4;
    localparam int K_D = 0, K_I = 1, K_W = 2;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_miss = 1'b0, d_miss = 1'b0, wr_req = 1'b0, mem_valid = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, wr_addr = '0, wr_data = '0, mem_data_out = '0;
    logic        mem_en, mem_wr, i_data_we, i_tag_we, d_data_we, d_tag_we, wr_done, busy;
    logic [15:0] mem_addr, mem_data_in, fill_addr, fill_data;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] perf_i_fills, perf_d_fills, perf_writes, perf_busy_cyc;
`endif

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLK(WORDS), .MEM_LAT(MEM_LAT),
                  .I_STARVE_MAX(I_STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .i_miss(i_miss), .i_addr(i_addr), .d_miss(d_miss), .d_addr(d_addr),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .mem_data_out(mem_data_out),
        .mem_valid(mem_valid), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .fill_addr(fill_addr), .fill_data(fill_data),
        .i_data_we(i_data_we), .i_tag_we(i_tag_we), .d_data_we(d_data_we), .d_tag_we(d_tag_we),
        .wr_done(wr_done), .busy(busy)
`ifdef MEM_ARB_PERF_EN
        , .perf_i_fills(perf_i_fills), .perf_d_fills(perf_d_fills),
        .perf_writes(perf_writes), .perf_busy_cyc(perf_busy_cyc)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic summary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
    endtask

    // Memory model: word store with default pattern, fixed read latency, in-order returns.
    logic [15:0] wmem [logic [15:0]];
    logic [15:0] rq_addr[$];
    int unsigned rq_due[$];

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (wmem.exists(a)) return wmem[a];
        return (a * 16'd25173) ^ 16'h3C5A;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (rq_due.size() > 0 && rq_due[0] == cyc) begin
            mem_valid    = 1'b1;
            mem_data_out = mem_rd(rq_addr[0]);
            void'(rq_due.pop_front());
            void'(rq_addr.pop_front());
        end else begin
            mem_valid    = 1'b0;
            mem_data_out = 16'($urandom);
        end
    end

    always @(negedge clk) begin
        if (mem_en && !mem_wr) begin
            rq_addr.push_back(mem_addr);
            rq_due.push_back(cyc + MEM_LAT);
        end
        if (mem_en && mem_wr) wmem[mem_addr] = mem_data_in;
    end

    // Requesters: each holds its request until the matching acknowledge, then presents the next.
    logic [15:0] dq[$], iq[$], wq_a[$], wq_d[$];

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (d_tag_we && dq.size() > 0) void'(dq.pop_front());
            if (i_tag_we && iq.size() > 0) void'(iq.pop_front());
            if (wr_done && wq_a.size() > 0) begin
                void'(wq_a.pop_front());
                void'(wq_d.pop_front());
            end
        end
        d_miss  = dq.size() > 0;
        d_addr  = d_miss ? dq[0] : '0;
        i_miss  = iq.size() > 0;
        i_addr  = i_miss ? iq[0] : '0;
        wr_req  = wq_a.size() > 0;
        wr_addr = wr_req ? wq_a[0] : '0;
        wr_data = wr_req ? wq_d[0] : '0;
    end

    // Reference model: grant order from the priority and starvation rules, all requests pending at once.
    op_t         exp_q[$];
    logic [15:0] st_d[$], st_i[$], st_wa[$], st_wd[$];
    int unsigned load_cyc = 0;
    bit          sc_first = 1'b0;

    task automatic load_scenario();
        int  starve;
        int  di, ii, wi;
        op_t o;
        starve = 0; di = 0; ii = 0; wi = 0;
        while (di < st_d.size() || ii < st_i.size() || wi < st_wa.size()) begin
            o.data = '0;
            if (ii < st_i.size() && starve >= I_STARVE_MAX) begin
                o.kind = K_I; o.addr = st_i[ii]; ii++;
            end else if (di < st_d.size()) begin
                o.kind = K_D; o.addr = st_d[di]; di++;
            end else if (wi < st_wa.size()) begin
                o.kind = K_W; o.addr = st_wa[wi]; o.data = st_wd[wi]; wi++;
            end else begin
                o.kind = K_I; o.addr = st_i[ii]; ii++;
            end
            if (o.kind == K_I) starve = 0;
            else if (ii < st_i.size() && starve < I_STARVE_MAX) starve++;
            exp_q.push_back(o);
        end
        foreach (st_d[k])  dq.push_back(st_d[k]);
        foreach (st_i[k])  iq.push_back(st_i[k]);
        foreach (st_wa[k]) begin wq_a.push_back(st_wa[k]); wq_d.push_back(st_wd[k]); end
        st_d.delete(); st_i.delete(); st_wa.delete(); st_wd.delete();
        load_cyc = cyc;
        sc_first = 1'b1;
    endtask

    // Monitor: pops the expected operation when busy rises and checks every cycle of it.
    op_t         cur;
    bit          m_act = 1'b0, prev_busy = 1'b0, m_tag = 1'b0;
    int unsigned m_start = 0, m_last_end = 0, m_nis = 0, m_nw = 0, tag_cnt = 0;

    always @(negedge clk) begin
        logic        own_dwe, own_twe, oth, any_str;
        logic [15:0] exp_fa;
        int unsigned rel;
        if (i_tag_we || d_tag_we) tag_cnt++;
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (!busy && prev_busy) begin
                if (m_act) begin
                    chk("busy_len", cyc - m_start, (cur.kind == K_W) ? 1 : MEM_LAT + WORDS);
                    if (cur.kind != K_W) begin
                        chk("words_returned", m_nw, WORDS);
                        chk("reads_issued", m_nis, WORDS);
                        chk("tag_seen", m_tag, 1);
                    end
                end
                m_last_end = cyc;
                m_act = 1'b0;
            end
            if (busy && !prev_busy) begin
                chk("op_expected", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    m_act = 1'b1;
                end
                if (sc_first) chk("grant_latency", cyc - load_cyc, 1);
                else          chk("idle_gap", cyc - m_last_end, 1);
                sc_first = 1'b0;
                m_start = cyc; m_nis = 0; m_nw = 0; m_tag = 1'b0;
            end
            if (busy && m_act) begin
                rel = cyc - m_start;
                if (cur.kind == K_W) begin
                    chk("wr_rel", rel, 0);
                    chk("wr_done", wr_done, 1);
                    chk("wr_mem_ctl", {mem_en, mem_wr}, 2'b11);
                    chk("wr_addr", mem_addr, cur.addr);
                    chk("wr_data", mem_data_in, cur.data);
                    chk("wr_fill_strobes", {i_data_we, i_tag_we, d_data_we, d_tag_we}, 0);
                end else begin
                    own_dwe = (cur.kind == K_I) ? i_data_we : d_data_we;
                    own_twe = (cur.kind == K_I) ? i_tag_we : d_tag_we;
                    oth     = (cur.kind == K_I) ? (d_data_we | d_tag_we) : (i_data_we | i_tag_we);
                    if (oth) chk("cross_strobe", oth, 0);
                    if (wr_done || mem_wr) chk("write_in_fill", {wr_done, mem_wr}, 0);
                    if (mem_en) begin
                        chk("issue_rel", rel, m_nis);
                        chk("issue_addr", mem_addr, (cur.addr & 16'hFFF0) | 16'(m_nis * 2));
                        m_nis++;
                    end
                    if (own_dwe) begin
                        exp_fa = (cur.addr & 16'hFFF0) | 16'(m_nw * 2);
                        chk("data_rel", rel, MEM_LAT + m_nw);
                        chk("fill_addr", fill_addr, exp_fa);
                        chk("fill_data", fill_data, mem_rd(exp_fa));
                        chk("tag_with_last", own_twe, m_nw == WORDS - 1);
                        if (own_twe) m_tag = 1'b1;
                        m_nw++;
                    end else if (own_twe) begin
                        chk("tag_without_data", own_twe, 0);
                    end
                end
            end
            if (!busy) begin
                any_str = mem_en | mem_wr | wr_done | i_data_we | i_tag_we | d_data_we | d_tag_we;
                if (any_str) chk("idle_strobe", any_str, 0);
            end
            prev_busy = busy;
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mem"}, {mem_en, mem_wr, mem_addr, mem_data_in}, 0);
        chk({tag, "_fill"}, {fill_addr, fill_data}, 0);
        chk({tag, "_strobes"}, {i_data_we, i_tag_we, d_data_we, d_tag_we, wr_done, busy}, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || m_act || busy || dq.size() > 0 || iq.size() > 0 || wq_a.size() > 0)
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 64'(n < 3000), 1);
        if (n >= 3000) begin
            summary();
            $finish;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run();
        @(posedge clk);
        #1 load_scenario();
        drain();
    endtask

    initial begin
        int          n;
        int unsigned t0;
        #1 rst_n = 1'b0;
        #1 chk_outputs_zero("reset_async");
        repeat (3) @(negedge clk);
        #2 chk_outputs_zero("reset_held");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2 chk_outputs_zero("post_reset_idle");

        // D and I together: D first, I one idle cycle later
        st_d.push_back(16'h5A70); st_i.push_back(16'hC3D2);
        run();
        // Store with pending I miss: write then I fill
        st_wa.push_back(16'h0040); st_wd.push_back(16'hBEEF); st_i.push_back(16'h0812);
        run();
`ifdef MEM_ARB_PERF_EN
        chk("perf_d_fills", perf_d_fills, 1);
        chk("perf_i_fills", perf_i_fills, 2);
        chk("perf_writes", perf_writes, 1);
        chk("perf_busy_cyc", perf_busy_cyc, 3 * (MEM_LAT + WORDS) + 1);
`endif
        st_d.push_back(16'h1234);
        run();
        // Starvation: I held against six stores
        st_i.push_back(16'h7F30);
        for (int k = 0; k < 6; k++) begin
            st_wa.push_back(16'h0100 + 16'(k * 2));
            st_wd.push_back(16'hA000 + 16'(k));
        end
        run();
        chk("store_6_written", wmem[16'h010A], 16'hA005);

        // Reset during the third returned word of a D fill
        st_d.push_back(16'h2468);
        @(posedge clk);
        #1 load_scenario();
        n = 0;
        while (!(m_act && m_nw >= 3) && n < 100) begin
            @(negedge clk);
            #2 n++;
        end
        chk("reset_reach_word3", 64'(m_nw), 3);
        rst_n = 1'b0;
        #1 chk_outputs_zero("reset_mid_fill");
        exp_q.delete(); dq.delete();
        d_miss = 1'b0; d_addr = '0;
        m_act = 1'b0; prev_busy = 1'b0;
        t0 = tag_cnt;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        #2;
        chk("no_tag_after_reset", tag_cnt - t0, 0);
        chk("idle_after_reset", busy, 0);
        chk("stale_reads_drained", rq_due.size(), 0);

        for (int s = 0; s < 30; s++) begin
            int nd, ni, nw;
            nd = $urandom_range(0, 2);
            ni = $urandom_range(0, 2);
            nw = $urandom_range(0, 6);
            for (int k = 0; k < nd; k++) st_d.push_back(16'($urandom));
            for (int k = 0; k < ni; k++) st_i.push_back(16'($urandom));
            for (int k = 0; k < nw; k++) begin
                st_wa.push_back(16'($urandom) & 16'hFFFE);
                st_wd.push_back(16'($urandom));
            end
            run();
        end

        summary();
        $finish;
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog actual=running required=finished cycle=%0d", cyc);
        summary();
        $finish;
    end
endmodule
